// File: rtl/regfile_2r1w.sv
// Two-read, one-write integer register file with registered read ports.
// Entry 0 reads as zero, and a same-cycle write is forwarded to both read ports.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_readEnA,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic              ctrl_readEnB,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              valid_readA,
    output logic              valid_readB
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] entries [DEPTH];
    logic [DEPTH-1:0]  entry_en;
    logic [DATA_W-1:0] read_a_next;
    logic [DATA_W-1:0] read_b_next;

    // One-hot entry enable; index 0 never gets one, so it stays at its reset value.
    always_comb begin
        entry_en = '0;
        if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
            entry_en[ctrl_writeReg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (entry_en[i]) begin
                    entries[i] <= data_writeReg;
                end
            end
        end
    end

    // Zero check comes first so a write to entry 0 can never be forwarded.
    always_comb begin
        read_a_next = entries[ctrl_readRegA];
        if (ctrl_readRegA == '0) begin
            read_a_next = '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
            read_a_next = data_writeReg;
        end
    end

    always_comb begin
        read_b_next = entries[ctrl_readRegB];
        if (ctrl_readRegB == '0) begin
            read_b_next = '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
            read_b_next = data_writeReg;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            data_readRegA <= '0;
            data_readRegB <= '0;
            valid_readA   <= 1'b0;
            valid_readB   <= 1'b0;
        end else begin
            valid_readA <= ctrl_readEnA;
            valid_readB <= ctrl_readEnB;
            if (ctrl_readEnA) begin
                data_readRegA <= read_a_next;
            end
            if (ctrl_readEnB) begin
                data_readRegB <= read_b_next;
            end
        end
    end

endmodule
